ft600_responder: RTL and testbench

Synthesizable emulation of the FT600Q device side of the 16-bit 245 synchronous FIFO bus. It is the responder to the `ftdi_245fifo` master, so FPGA-internal loopback and hardware-in-the-loop benches can run without a USB host. Host-to-FPGA traffic comes from an internal incrementing-byte generator. FPGA-to-host words are buffered in a FIFO and presented on a valid/ready stream for checking.

---
 rtl/ft600_responder.sv | 157 +++++++++++++++
 tb/tb_ft600_responder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft600_responder.sv
`default_nettype none
// ============================================================================
// Module   : ft600_responder
// Brief    : FT600Q device-side model of the 16-bit 245 synchronous FIFO bus:
//            incrementing-byte read source, FIFO-backed write sink.
// Revision : 1.0 - initial release
// ============================================================================
module ft600_responder #(
    parameter int AEXP       = 10,
    parameter int TXE_MARGIN = 4,
    parameter int RX_BURST   = 256,
    parameter int RX_GAP     = 16
) (
    input  logic        clk,
    input  logic        rstn_async,
    output logic        usb_rxf,
    output logic        usb_txe,
    input  logic        usb_oe,
    input  logic        usb_rd,
    input  logic        usb_wr,
    input  logic [15:0] usb_d_i,
    input  logic [1:0]  usb_be_i,
    output logic [15:0] usb_d_o,
    output logic [1:0]  usb_be_o,
    output logic        usb_d_oe,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic [1:0]  m_be,
    output logic        tx_overflow,
    output logic        bus_err
);

    localparam int             c_depth    = 1 << AEXP;
    localparam logic [AEXP:0]  c_depth_w  = (AEXP+1)'(c_depth);
    localparam logic [AEXP:0]  c_margin   = (AEXP+1)'(TXE_MARGIN);
    localparam logic [15:0]    c_burst    = 16'(RX_BURST);
    localparam logic [15:0]    c_gap_last = 16'(RX_GAP - 1);
    localparam bit             c_gap_zero = (RX_GAP == 0);

    typedef enum logic [0:0] {
        ST_AVAIL = 1'b0,
        ST_GAP   = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [15:0]    r_gap_cnt, w_gap_cnt_nxt;
    logic [15:0]    r_word_cnt, w_word_cnt_nxt;
    logic [7:0]     r_seed, w_seed_nxt;
    logic [15:0]    r_d_o;
    logic           r_bus_err;
    logic           r_txe;
    logic           r_ovf;

    logic [17:0]    r_mem [0:c_depth-1];
    logic [AEXP-1:0] r_wptr, r_rptr;
    logic [AEXP:0]  r_count, w_count_nxt, w_free_nxt;

    logic w_rd_take, w_proto_err, w_full, w_pop, w_push, w_drop;

    // A read only counts when the master both strobes and enables the bus.
    assign w_rd_take   = ~usb_rd & ~usb_oe & (r_state == ST_AVAIL);
    assign w_proto_err = (~usb_rd & ~usb_wr) | (~usb_rd & usb_oe) |
                         (~usb_wr & ~usb_oe) | (~usb_rd & (r_state == ST_GAP));

    always_comb begin
        w_state_nxt    = r_state;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_word_cnt_nxt = r_word_cnt;
        w_seed_nxt     = r_seed;
        case (r_state)
            ST_GAP: begin
                if (c_gap_zero || (r_gap_cnt == c_gap_last)) begin
                    w_state_nxt    = ST_AVAIL;
                    w_gap_cnt_nxt  = '0;
                    w_word_cnt_nxt = c_burst;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 16'd1;
                end
            end
            default: begin
                if (w_rd_take) begin
                    w_seed_nxt     = r_seed + 8'd2;
                    w_word_cnt_nxt = r_word_cnt - 16'd1;
                    if (r_word_cnt == 16'd1) begin
                        // With no gap the next burst begins on the very next cycle.
                        if (c_gap_zero) begin
                            w_word_cnt_nxt = c_burst;
                        end else begin
                            w_state_nxt   = ST_GAP;
                            w_gap_cnt_nxt = '0;
                        end
                    end
                end
            end
        endcase
    end

    assign w_full = (r_count == c_depth_w);
    assign w_pop  = (r_count != '0) & m_ready;
    // A same-cycle pop frees the slot a write into a full FIFO needs.
    assign w_push = ~usb_wr & (~w_full | w_pop);
    assign w_drop = ~usb_wr & w_full & ~w_pop;

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AEXP+1)'(1);
            2'b01:   w_count_nxt = r_count - (AEXP+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end
    assign w_free_nxt = c_depth_w - w_count_nxt;

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            r_state    <= ST_GAP;
            r_gap_cnt  <= '0;
            r_word_cnt <= '0;
            r_seed     <= '0;
            r_d_o      <= 16'h0100;
            r_bus_err  <= 1'b0;
            r_txe      <= 1'b0;
            r_ovf      <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_seed     <= w_seed_nxt;
            r_d_o      <= {w_seed_nxt + 8'd1, w_seed_nxt};
            r_bus_err  <= r_bus_err | w_proto_err;
            r_txe      <= (w_free_nxt < c_margin);
            r_ovf      <= r_ovf | w_drop;
            r_count    <= w_count_nxt;
            if (w_push) r_wptr <= r_wptr + AEXP'(1);
            if (w_pop)  r_rptr <= r_rptr + AEXP'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {usb_be_i, usb_d_i};
    end

    assign usb_rxf        = (r_state == ST_GAP);
    assign usb_txe        = r_txe;
    assign usb_d_o        = r_d_o;
    assign usb_be_o       = 2'b11;
    assign usb_d_oe       = ~usb_oe;
    assign m_valid        = (r_count != '0);
    assign {m_be, m_data} = r_mem[r_rptr];
    assign tx_overflow    = r_ovf;
    assign bus_err        = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_ft600_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft600_responder
// Brief    : Randomized self-checking bench for ft600_responder against a
//            byte-stream and queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft600_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rstn_async;
    logic        usb_rxf, usb_txe;
    logic        usb_oe, usb_rd, usb_wr;
    logic [15:0] usb_d_i;
    logic [1:0]  usb_be_i;
    logic [15:0] usb_d_o;
    logic [1:0]  usb_be_o;
    logic        usb_d_oe;
    logic        m_valid, m_ready;
    logic [15:0] m_data;
    logic [1:0]  m_be;
    logic        tx_overflow, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ft600_responder #(
        .AEXP(10), .TXE_MARGIN(4), .RX_BURST(4), .RX_GAP(16)
    ) dut (
        .clk(clk), .rstn_async(rstn_async),
        .usb_rxf(usb_rxf), .usb_txe(usb_txe),
        .usb_oe(usb_oe), .usb_rd(usb_rd), .usb_wr(usb_wr),
        .usb_d_i(usb_d_i), .usb_be_i(usb_be_i),
        .usb_d_o(usb_d_o), .usb_be_o(usb_be_o), .usb_d_oe(usb_d_oe),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_be(m_be),
        .tx_overflow(tx_overflow), .bus_err(bus_err)
    );

    task automatic idle_bus();
        usb_oe   = 1'b1;
        usb_rd   = 1'b1;
        usb_wr   = 1'b1;
        usb_d_i  = '0;
        usb_be_i = '0;
        m_ready  = 1'b0;
    endtask

    // Leaves the caller on a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        idle_bus();
        rstn_async = 1'b0;
        @(negedge clk);
        rstn_async = 1'b1;
    endtask

    task automatic wait_avail(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (usb_rxf === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        idle_bus();
        rstn_async = 1'b1;
        #1 rstn_async = 1'b0;
        #1;
        checks++; if (usb_rxf !== 1'b1) begin errors++; $display("FAIL reset_rxf got %b want 1", usb_rxf); end
        checks++; if (usb_txe !== 1'b0) begin errors++; $display("FAIL reset_txe got %b want 0", usb_txe); end
        checks++; if (usb_d_o !== 16'h0100) begin errors++; $display("FAIL reset_d_o got %h want 0100", usb_d_o); end
        checks++; if (usb_be_o !== 2'b11) begin errors++; $display("FAIL reset_be_o got %b want 11", usb_be_o); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if ({tx_overflow, bus_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {tx_overflow, bus_err}); end
        @(negedge clk);
        rstn_async = 1'b1;
        n = 0;
        while (usb_rxf === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 16) begin errors++; $display("FAIL first_gap_len got %0d want 16", n); end
        checks++; if (usb_d_o !== 16'h0100) begin errors++; $display("FAIL first_word got %h want 0100", usb_d_o); end
        checks++; if ({m_valid, tx_overflow, bus_err} !== 3'b000) begin errors++; $display("FAIL idle_state got %b want 000", {m_valid, tx_overflow, bus_err}); end
        usb_oe = 1'b0;
        #1;
        checks++; if (usb_d_oe !== 1'b1) begin errors++; $display("FAIL d_oe_on got %b want 1", usb_d_oe); end
        usb_oe = 1'b1;
        #1;
        checks++; if (usb_d_oe !== 1'b0) begin errors++; $display("FAIL d_oe_off got %b want 0", usb_d_oe); end
    endtask

    // Reads 130 bursts with random stalls; the bytes must form one unbroken count.
    task automatic test_read_bursts();
        int  eb, words, bursts, gap;
        bit  expect_gap, prev_rxf;
        logic [7:0] lo, hi;
        do_reset();
        usb_oe = 1'b0;
        eb = 0; words = 0; bursts = 0; gap = 0; expect_gap = 0; prev_rxf = 1'b1;
        for (int cyc = 0; cyc < 6000 && bursts < 130; cyc++) begin
            if (expect_gap) begin
                checks++; if (usb_rxf !== 1'b1) begin errors++; $display("FAIL rxf_after_last got %b want 1 burst %0d", usb_rxf, bursts); end
                expect_gap = 0;
            end
            if (usb_rxf === 1'b1) begin
                gap++;
                usb_rd = 1'b1;
            end else begin
                if (prev_rxf) begin
                    checks++; if (gap != 16) begin errors++; $display("FAIL gap_len got %0d want 16", gap); end
                    gap = 0;
                    if (bursts == 1) begin
                        checks++; if (usb_d_o !== 16'h0908) begin errors++; $display("FAIL second_burst_start got %h want 0908", usb_d_o); end
                    end
                end
                lo = 8'(eb);
                hi = 8'(eb + 1);
                checks++; if ({usb_be_o, usb_d_o} !== {2'b11, hi, lo}) begin errors++; $display("FAIL read_word got %h/%b want %h/11", usb_d_o, usb_be_o, {hi, lo}); end
                usb_rd = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
                if (usb_rd == 1'b0) begin
                    eb = (eb + 2) % 256;
                    words++;
                    if (words == 4) begin
                        words = 0;
                        bursts++;
                        expect_gap = 1;
                    end
                end
            end
            prev_rxf = usb_rxf;
            @(negedge clk);
        end
        usb_rd = 1'b1;
        usb_oe = 1'b1;
        checks++; if (bursts != 130) begin errors++; $display("FAIL burst_count got %0d want 130", bursts); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL read_bus_err got %b want 0", bus_err); end
    endtask

    task automatic test_fill_overflow();
        logic [17:0] q[$];
        logic [17:0] exp_w;
        int n;
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            checks++; if (usb_txe !== ((DEPTH - q.size()) < 4)) begin errors++; $display("FAIL fill_txe got %b at %0d words", usb_txe, q.size()); end
            checks++; if (m_valid !== (q.size() > 0)) begin errors++; $display("FAIL fill_valid got %b at %0d words", m_valid, q.size()); end
            if (q.size() > 0) begin
                checks++; if ({m_be, m_data} !== q[0]) begin errors++; $display("FAIL fill_head got %h want %h", {m_be, m_data}, q[0]); end
            end
            checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL early_overflow got %b want 0 at %0d", tx_overflow, k); end
            usb_wr   = 1'b0;
            usb_d_i  = (k < DEPTH) ? 16'(k) : 16'hFFFF;
            usb_be_i = 2'($urandom);
            if (q.size() < DEPTH) q.push_back({usb_be_i, usb_d_i});
            @(negedge clk);
        end
        usb_wr = 1'b1;
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", tx_overflow); end
        checks++; if (usb_txe !== 1'b1) begin errors++; $display("FAIL full_txe got %b want 1", usb_txe); end
        m_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < DEPTH + 16) begin
            if (n == 0) begin
                checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL drain_first got %h want 0000", m_data); end
            end
            exp_w = q.pop_front();
            checks++; if ({m_valid, m_be, m_data} !== {1'b1, exp_w}) begin errors++; $display("FAIL drain_word got %b/%h want 1/%h", m_valid, {m_be, m_data}, exp_w); end
            n++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %b want 0", m_valid); end
        checks++; if (usb_txe !== 1'b0) begin errors++; $display("FAIL drained_txe got %b want 0", usb_txe); end
    endtask

    task automatic test_full_pop_push();
        logic [17:0] q[$];
        logic [17:0] w;
        bit rdy;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            usb_wr   = 1'b0;
            usb_d_i  = 16'($urandom);
            usb_be_i = 2'($urandom);
            q.push_back({usb_be_i, usb_d_i});
            @(negedge clk);
        end
        checks++; if ({usb_txe, m_valid} !== 2'b11) begin errors++; $display("FAIL full_before got %b want 11", {usb_txe, m_valid}); end
        w        = 18'($urandom);
        usb_d_i  = w[15:0];
        usb_be_i = w[17:16];
        m_ready  = 1'b1;
        void'(q.pop_front());
        q.push_back(w);
        @(negedge clk);
        usb_wr  = 1'b1;
        m_ready = 1'b0;
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL full_swap_ovf got %b want 0", tx_overflow); end
        checks++; if (usb_txe !== 1'b1) begin errors++; $display("FAIL full_swap_txe got %b want 1", usb_txe); end
        for (int cyc = 0; cyc < 6000 && q.size() > 0; cyc++) begin
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL swap_valid got %b want 1 with %0d left", m_valid, q.size()); end
            checks++; if ({m_be, m_data} !== q[0]) begin errors++; $display("FAIL swap_word got %h want %h", {m_be, m_data}, q[0]); end
            rdy     = 1'($urandom_range(0, 1));
            m_ready = rdy;
            if (rdy) void'(q.pop_front());
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL swap_drain_timeout got %0d left want 0", q.size()); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL swap_empty got %b want 0", m_valid); end
    endtask

    // Random concurrent writes and pops against an occupancy-bounded queue.
    task automatic test_random_stream();
        logic [17:0] q[$];
        bit pop, wr, ovf;
        do_reset();
        ovf = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            checks++; if (usb_txe !== ((DEPTH - q.size()) < 4)) begin errors++; $display("FAIL rand_txe got %b at %0d words", usb_txe, q.size()); end
            checks++; if (m_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid got %b at %0d words", m_valid, q.size()); end
            if (q.size() > 0) begin
                checks++; if ({m_be, m_data} !== q[0]) begin errors++; $display("FAIL rand_head got %h want %h", {m_be, m_data}, q[0]); end
            end
            checks++; if (tx_overflow !== ovf) begin errors++; $display("FAIL rand_ovf got %b want %b", tx_overflow, ovf); end
            wr       = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 3) == 0);
            usb_wr   = ~wr;
            usb_d_i  = 16'($urandom);
            usb_be_i = 2'($urandom);
            pop = m_ready && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (wr) begin
                if (q.size() < DEPTH) q.push_back({usb_be_i, usb_d_i});
                else ovf = 1;
            end
            @(negedge clk);
        end
        idle_bus();
    endtask

    task automatic test_protocol_errors();
        bit ok;
        do_reset();
        wait_avail(ok);
        checks++; if (!ok) begin errors++; $display("FAIL perr_avail_timeout got 0 want 1"); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL perr_clean got %b want 0", bus_err); end
        usb_oe = 1'b0; usb_rd = 1'b0; usb_wr = 1'b0;
        @(negedge clk);
        idle_bus();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL rd_wr_both got %b want 1", bus_err); end
        repeat (5) @(negedge clk);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky got %b want 1", bus_err); end

        do_reset();
        checks++; if ({usb_rxf, bus_err} !== 2'b10) begin errors++; $display("FAIL gap_before got %b want 10", {usb_rxf, bus_err}); end
        usb_oe = 1'b0; usb_rd = 1'b0;
        @(negedge clk);
        usb_rd = 1'b1; usb_oe = 1'b1;
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL rd_in_gap got %b want 1", bus_err); end
        wait_avail(ok);
        checks++; if (!ok || usb_d_o !== 16'h0100) begin errors++; $display("FAIL seed_after_gap_rd got %h want 0100", usb_d_o); end

        do_reset();
        wait_avail(ok);
        usb_rd = 1'b0;
        @(negedge clk);
        usb_rd = 1'b1;
        checks++; if ({bus_err, usb_d_o} !== {1'b1, 16'h0100}) begin errors++; $display("FAIL rd_without_oe got %b/%h want 1/0100", bus_err, usb_d_o); end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        do_reset();
        repeat (3) begin
            usb_wr  = 1'b0;
            usb_d_i = 16'($urandom);
            @(negedge clk);
        end
        usb_wr = 1'b1;
        wait_avail(ok);
        usb_oe = 1'b0; usb_rd = 1'b0;
        repeat (2) @(negedge clk);
        usb_rd = 1'b1;
        checks++; if ({ok, m_valid, usb_d_o} !== {2'b11, 16'h0504}) begin errors++; $display("FAIL pre_reset got %b/%b/%h want 1/1/0504", ok, m_valid, usb_d_o); end
        #2 rstn_async = 1'b0;
        #1;
        checks++; if ({usb_rxf, m_valid, usb_d_o} !== {2'b10, 16'h0100}) begin errors++; $display("FAIL async_reset got %b/%b/%h want 1/0/0100", usb_rxf, m_valid, usb_d_o); end
        @(negedge clk);
        rstn_async = 1'b1;
        usb_oe = 1'b1;
        wait_avail(ok);
        usb_oe = 1'b0;
        checks++; if (!ok || usb_d_o !== 16'h0100) begin errors++; $display("FAIL restart_word got %h want 0100", usb_d_o); end
        usb_rd = 1'b0;
        @(negedge clk);
        usb_rd = 1'b1;
        checks++; if (usb_d_o !== 16'h0302) begin errors++; $display("FAIL restart_next got %h want 0302", usb_d_o); end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_read_bursts();
        test_fill_overflow();
        test_full_pop_push();
        test_random_stream();
        test_protocol_errors();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
